// File: rtl/quad_decoder_ext.sv
// Quadrature A/B/Z decoder: synchronised, glitch-filtered inputs, 1x/2x/4x decode,
// signed position with symmetric wrap, preset, index clear/latch and sticky error.
module quad_decoder_ext #(
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4,
    parameter int MAX_POS  = 1048575
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ain,
    input  logic                    bin,
    input  logic                    zin,
    input  logic [1:0]              mode,
    input  logic                    dir_inv,
    input  logic [1:0]              z_mode,
    input  logic                    preset_ld,
    input  logic signed [CNT_W-1:0] preset_val,
    input  logic                    err_clr,
    output logic signed [CNT_W-1:0] pos,
    output logic signed [CNT_W-1:0] z_latch,
    output logic [7:0]              z_cnt,
    output logic                    dir,
    output logic                    step,
    output logic                    err
);

    localparam logic [3:0]              FILT_TC = 4'(FILT_LEN - 1);
    localparam logic signed [CNT_W-1:0] POS_MAX = CNT_W'(MAX_POS);
    localparam logic signed [CNT_W-1:0] NEG_MAX = -POS_MAX;

    // channel bit order everywhere: [2]=A, [1]=B, [0]=Z
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       filt_q, filt_d;
    logic [2:0][3:0]  fcnt_q, fcnt_d;
    logic [1:0]       ab_prev_q, ab_prev_d;
    logic             z_prev_q, z_prev_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic signed [CNT_W-1:0] pos_q, pos_d;
    logic signed [CNT_W-1:0] z_latch_q, z_latch_d;
    logic [7:0]       z_cnt_q, z_cnt_d;

    logic [1:0] ab_cur;
    logic [1:0] gdiff;
    logic       is_fwd, is_rev, is_bad, qual;
    logic       z_rise, z_clr;

    // Position of an AB state along the forward Gray sequence 00->10->11->01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_idx = 2'd0;
            2'b10:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_TC) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        ab_cur    = filt_q[2:1];
        ab_prev_d = ab_cur;
        gdiff     = gray_idx(ab_cur) - gray_idx(ab_prev_q);
        is_fwd    = (gdiff == 2'd1);
        is_rev    = (gdiff == 2'd3);
        is_bad    = (gdiff == 2'd2);
        case (mode)
            2'b01:   qual = ab_cur[1] ^ ab_prev_q[1];
            2'b10:   qual = (ab_prev_q == 2'b00 && ab_cur == 2'b10) ||
                            (ab_prev_q == 2'b10 && ab_cur == 2'b00);
            default: qual = 1'b1;
        endcase
        step_d = (is_fwd | is_rev) & qual;
        dir_d  = step_d ? (is_fwd ^ dir_inv) : dir_q;
        err_d  = is_bad | (err_q & ~err_clr);
    end

    always_comb begin
        z_prev_d  = filt_q[0];
        z_rise    = filt_q[0] & ~z_prev_q;
        z_clr     = z_rise && (z_mode == 2'b10 || (z_mode == 2'b01 && z_cnt_q == 8'd0));
        z_cnt_d   = (z_rise && z_cnt_q != 8'd255) ? z_cnt_q + 8'd1 : z_cnt_q;
        z_latch_d = (z_rise && z_mode != 2'b00) ? pos_q : z_latch_q;

        pos_d = pos_q;
        if (preset_ld) begin
            pos_d = preset_val;
        end else if (z_clr) begin
            pos_d = '0;
        end else if (step_q) begin
            // an out-of-range preset wraps to 0 on the next step either way
            if (dir_q) begin
                pos_d = (pos_q >= POS_MAX || pos_q < NEG_MAX) ? '0 : pos_q + CNT_W'(1);
            end else begin
                pos_d = (pos_q <= NEG_MAX || pos_q > POS_MAX) ? '0 : pos_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 3'b111;
            sync2_q   <= 3'b111;
            filt_q    <= 3'b111;
            fcnt_q    <= '0;
            ab_prev_q <= 2'b11;
            z_prev_q  <= 1'b1;
            step_q    <= 1'b0;
            dir_q     <= 1'b1;
            err_q     <= 1'b0;
            pos_q     <= '0;
            z_latch_q <= '0;
            z_cnt_q   <= 8'd0;
        end else begin
            sync1_q   <= {ain, bin, zin};
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            ab_prev_q <= ab_prev_d;
            z_prev_q  <= z_prev_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            pos_q     <= pos_d;
            z_latch_q <= z_latch_d;
            z_cnt_q   <= z_cnt_d;
        end
    end

    assign pos     = pos_q;
    assign z_latch = z_latch_q;
    assign z_cnt   = z_cnt_q;
    assign dir     = dir_q;
    assign step    = step_q;
    assign err     = err_q;

endmodule

// File: tb/tb_quad_decoder_ext.sv
// Bench for quad_decoder_ext: vector table, directed corner sequences and a
// randomized transition stream checked against a Gray-index position model.
module tb_quad_decoder_ext;

    localparam longint MAXP = 1048575;

    logic clk = 1'b0;
    logic rst_n, ain, bin, zin, dir_inv, preset_ld, err_clr;
    logic [1:0] mode, z_mode;
    logic signed [31:0] preset_val;
    logic signed [31:0] pos, z_latch;
    logic [7:0] z_cnt;
    logic dir, step, err;

    quad_decoder_ext dut (
        .clk(clk), .rst_n(rst_n), .ain(ain), .bin(bin), .zin(zin),
        .mode(mode), .dir_inv(dir_inv), .z_mode(z_mode),
        .preset_ld(preset_ld), .preset_val(preset_val), .err_clr(err_clr),
        .pos(pos), .z_latch(z_latch), .z_cnt(z_cnt),
        .dir(dir), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int step_seen = 0;
    logic [1:0] cur_ab;

    always @(negedge clk) if (rst_n && step) step_seen <= step_seen + 1;

    typedef struct {
        logic [1:0] ab;
        logic [1:0] md;
        logic       inv;
        int         e_pos;
        logic       e_dir;
        logic       e_err;
    } vec_t;
    vec_t tbl[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ain = 1'b1; bin = 1'b1;
        mode = 2'b00; dir_inv = 1'b0; z_mode = 2'b00;
        preset_ld = 1'b0; preset_val = '0; err_clr = 1'b0;
        cur_ab = 2'b11;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic move(input logic [1:0] ab);
        ain = ab[1]; bin = ab[0]; cur_ab = ab;
        repeat (8) tick();
    endtask

    task automatic preset(input longint v);
        preset_val = v[31:0]; preset_ld = 1'b1;
        tick();
        preset_ld = 1'b0;
        tick();
    endtask

    function automatic logic [1:0] nxt_fwd(input logic [1:0] ab);
        case (ab)
            2'b00: return 2'b10;
            2'b10: return 2'b11;
            2'b11: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] nxt_rev(input logic [1:0] ab);
        case (ab)
            2'b10: return 2'b00;
            2'b11: return 2'b10;
            2'b01: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_pos"}, pos, 0);
        check({tag, "_zl"}, z_latch, 0);
        check({tag, "_zc"}, z_cnt, 0);
        check({tag, "_dir"}, dir, 1);
        check({tag, "_step"}, step, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // reference model state
    int     gidx[4] = '{0, 3, 1, 2};
    longint m_pos;
    logic   m_dir, m_err;
    int     m_steps;

    task automatic model_move(input logic [1:0] o, input logic [1:0] n,
                              input logic [1:0] md, input logic inv);
        int  d;
        logic counted, f;
        d = (gidx[n] - gidx[o] + 4) % 4;
        if (d == 2) begin
            m_err = 1'b1;
            return;
        end
        case (md)
            2'b01:   counted = (o[1] != n[1]);
            2'b10:   counted = (o == 2'b00 && n == 2'b10) || (o == 2'b10 && n == 2'b00);
            default: counted = 1'b1;
        endcase
        if (!counted) return;
        f = (d == 1) ^ inv;
        m_dir = f;
        m_steps++;
        if (f) m_pos = (m_pos >= MAXP || m_pos < -MAXP) ? 0 : m_pos + 1;
        else   m_pos = (m_pos <= -MAXP || m_pos > MAXP) ? 0 : m_pos - 1;
    endtask

    initial begin
        int n, s0, g, ch;
        logic [1:0] nab, o;
        longint pv;

        zin = 1'b1;
        do_reset();
        check_reset_vals("rst");

        tbl[0]  = '{2'b01, 2'b00, 1'b0, 1, 1'b1, 1'b0};
        tbl[1]  = '{2'b00, 2'b00, 1'b0, 2, 1'b1, 1'b0};
        tbl[2]  = '{2'b10, 2'b00, 1'b0, 3, 1'b1, 1'b0};
        tbl[3]  = '{2'b00, 2'b00, 1'b0, 2, 1'b0, 1'b0};
        tbl[4]  = '{2'b10, 2'b01, 1'b0, 3, 1'b1, 1'b0};
        tbl[5]  = '{2'b11, 2'b01, 1'b0, 3, 1'b1, 1'b0};
        tbl[6]  = '{2'b01, 2'b01, 1'b0, 4, 1'b1, 1'b0};
        tbl[7]  = '{2'b11, 2'b01, 1'b0, 3, 1'b0, 1'b0};
        tbl[8]  = '{2'b10, 2'b10, 1'b0, 3, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 2'b10, 1'b0, 2, 1'b0, 1'b0};
        tbl[10] = '{2'b10, 2'b10, 1'b0, 3, 1'b1, 1'b0};
        tbl[11] = '{2'b01, 2'b00, 1'b0, 3, 1'b1, 1'b1};
        tbl[12] = '{2'b00, 2'b00, 1'b1, 2, 1'b0, 1'b1};
        tbl[13] = '{2'b10, 2'b11, 1'b1, 1, 1'b0, 1'b1};
        tbl[14] = '{2'b00, 2'b11, 1'b0, 0, 1'b0, 1'b1};
        tbl[15] = '{2'b11, 2'b00, 1'b0, 0, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            mode = tbl[i].md; dir_inv = tbl[i].inv;
            move(tbl[i].ab);
            check($sformatf("tbl%0d_pos", i), pos, tbl[i].e_pos);
            check($sformatf("tbl%0d_dir", i), dir, tbl[i].e_dir);
            check($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
        check("tbl_errclr", err, 0);

        // 4x forward/reverse with latency
        do_reset();
        s0 = step_seen;
        nab = nxt_fwd(cur_ab);
        ain = nab[1]; bin = nab[0]; cur_ab = nab;
        n = 0;
        while (pos == 0 && n < 20) begin tick(); n++; end
        check("latency", n - 1, 7);
        if (n < 8) repeat (8 - n) tick();
        for (int i = 1; i < 40; i++) move(nxt_fwd(cur_ab));
        check("fwd4x_pos", pos, 40);
        check("fwd4x_steps", step_seen - s0, 40);
        check("fwd4x_dir", dir, 1);
        for (int i = 0; i < 40; i++) move(nxt_rev(cur_ab));
        check("rev4x_pos", pos, 0);
        check("rev4x_dir", dir, 0);

        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 40; i++) move(nxt_fwd(cur_ab));
        check("fwd2x_pos", pos, 20);
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 40; i++) move(nxt_fwd(cur_ab));
        check("fwd1x_pos", pos, 10);

        // glitch filtering
        do_reset();
        s0 = step_seen;
        ain = 1'b0; repeat (3) tick(); ain = 1'b1; repeat (10) tick();
        check("glitch3_pos", pos, 0);
        check("glitch3_steps", step_seen - s0, 0);
        ain = 1'b0; repeat (5) tick(); ain = 1'b1; repeat (3) tick();
        check("pulse5_mid_pos", pos, 1);
        repeat (10) tick();
        check("pulse5_pos", pos, 0);
        check("pulse5_steps", step_seen - s0, 2);
        check("pulse5_dir", dir, 0);

        // preset and wrap
        do_reset();
        preset(MAXP);
        check("preset_max", pos, MAXP);
        move(2'b01);
        check("wrap_fwd", pos, 0);
        preset(-MAXP);
        move(2'b11);
        check("wrap_rev", pos, 0);
        ain = 1'b0; bin = 1'b1; cur_ab = 2'b01;
        repeat (7) tick();
        check("coinc_step", step, 1);
        preset_val = 32'sd500; preset_ld = 1'b1; tick(); preset_ld = 1'b0;
        check("coinc_pos", pos, 500);
        repeat (3) tick();
        check("coinc_hold", pos, 500);
        preset(2000000);
        move(2'b11);
        check("oor_wrap", pos, 0);

        // index handling
        do_reset();
        zin = 1'b0; repeat (8) tick();
        check("z_fall_cnt", z_cnt, 0);
        z_mode = 2'b01;
        preset(123);
        zin = 1'b1; repeat (8) tick();
        check("z01a_pos", pos, 0);
        check("z01a_zl", z_latch, 123);
        check("z01a_zc", z_cnt, 1);
        zin = 1'b0; repeat (8) tick();
        preset(50);
        zin = 1'b1; repeat (8) tick();
        check("z01b_pos", pos, 50);
        check("z01b_zl", z_latch, 50);
        check("z01b_zc", z_cnt, 2);
        move(2'b01);
        check("z01b_count", pos, 51);
        z_mode = 2'b11;
        zin = 1'b0; repeat (8) tick();
        preset(77);
        zin = 1'b1; repeat (8) tick();
        check("z11_pos", pos, 77);
        check("z11_zl", z_latch, 77);
        check("z11_zc", z_cnt, 3);
        z_mode = 2'b10;
        zin = 1'b0; repeat (8) tick();
        preset(9);
        zin = 1'b1; repeat (8) tick();
        check("z10_pos", pos, 0);
        check("z10_zl", z_latch, 9);
        check("z10_zc", z_cnt, 4);
        z_mode = 2'b00;
        zin = 1'b0; repeat (8) tick();
        preset(5);
        zin = 1'b1; repeat (8) tick();
        check("z00_pos", pos, 5);
        check("z00_zl", z_latch, 9);
        check("z00_zc", z_cnt, 5);

        // illegal transition, inversion, mid-count reset
        do_reset();
        move(2'b01);
        move(2'b00);
        move(2'b11);
        check("illegal_err", err, 1);
        check("illegal_pos", pos, 2);
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
        check("errclr", err, 0);
        dir_inv = 1'b1;
        move(2'b01);
        move(2'b00);
        move(2'b10);
        check("inv_pos", pos, -1);
        check("inv_dir", dir, 0);
        move(2'b11);
        ain = 1'b0; cur_ab = 2'b01;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        rst_n = 1'b1;
        n = 0;
        while (pos == 0 && n < 20) begin tick(); n++; end
        check("midrst_latency", n - 1, 7);
        check("midrst_pos", pos, -1);

        // randomized stream against the model
        do_reset();
        m_pos = 0; m_dir = 1'b1; m_err = 1'b0; m_steps = 0;
        s0 = step_seen;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    case ($urandom_range(0, 3))
                        0: pv = MAXP - 1;
                        1: pv = -(MAXP - 1);
                        2: pv = MAXP + 3;
                        default: pv = longint'($urandom_range(0, 200)) - 100;
                    endcase
                    preset(pv);
                    m_pos = pv;
                end
                1: begin
                    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
                    m_err = 1'b0;
                end
                default: ;
            endcase
            mode = 2'($urandom_range(0, 3));
            dir_inv = 1'($urandom_range(0, 1));
            o = cur_ab;
            nab = cur_ab ^ 2'($urandom_range(1, 3));
            model_move(o, nab, mode, dir_inv);
            move(nab);
            check($sformatf("rnd%0d_pos", it), pos, m_pos);
            check($sformatf("rnd%0d_dir", it), dir, m_dir);
            check($sformatf("rnd%0d_err", it), err, m_err);
            check($sformatf("rnd%0d_steps", it), step_seen - s0, m_steps);
            if ($urandom_range(0, 3) == 0) begin
                g = $urandom_range(1, 3);
                ch = $urandom_range(0, 1);
                if (ch == 1) ain = ~ain; else bin = ~bin;
                repeat (g) tick();
                ain = cur_ab[1]; bin = cur_ab[0];
                repeat (8) tick();
                check($sformatf("rnd%0d_glitch", it), pos, m_pos);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
